// File: rtl/motor_pkg.sv
// Shared types and default speed limits for the motor drive path.
package motor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RAMP   = 2'd1,
      ST_CRUISE = 2'd2,
      ST_STOP   = 2'd3
   } ramp_state_t;

   localparam int DEF_CNT_W     = 22;
   localparam int DEF_PER_MIN   = 2000;
   localparam int DEF_PER_MAX   = 20000;
   localparam int DEF_RAMP_STEP = 100;

endpackage

// File: rtl/half_period_timer.sv
// Half-period counter: counts 0..cur_period-1 and flags the terminal count.
// Latency: tc is combinational from the registered count; no backpressure, free-running while enabled.
// Disabled -> counter held at 0.
module half_period_timer #(
   parameter int CNT_W = 22
) (
   input  logic             clock_100Mhz,
   input  logic             reset,
   input  logic             enable,
   input  logic [CNT_W-1:0] cur_period,
   output logic             tc
);

   logic [CNT_W-1:0] cnt;

   assign tc = enable && (cnt == cur_period - CNT_W'(1));

   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (!enable || tc) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/step_rate_ramp_ctrl.sv
// Motor step-rate controller: ramps the senal half-period linearly toward a commanded target.
// Latency: busy one cycle after command accept, first senal rise PER_MAX+1 cycles after accept.
// Backpressure: cmd_ready low while decelerating to stop, high otherwise.
module step_rate_ramp_ctrl
   import motor_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int PER_MIN   = DEF_PER_MIN,
   parameter int PER_MAX   = DEF_PER_MAX,
   parameter int RAMP_STEP = DEF_RAMP_STEP
) (
   input  logic             clock_100Mhz,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_run,
   input  logic [CNT_W-1:0] cmd_period,
   output logic             senal,
   output logic             busy,
   output logic             at_speed,
   output logic [CNT_W-1:0] cur_period
);

   localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(PER_MIN);
   localparam logic [CNT_W-1:0] P_MAX  = CNT_W'(PER_MAX);
   localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(RAMP_STEP);

   ramp_state_t      state, state_nxt;
   logic [CNT_W-1:0] target, target_nxt;
   logic [CNT_W-1:0] clamped, ramped;
   logic [CNT_W:0]   cur_x, tgt_x;
   logic             tc, cmd_acc;

   assign cmd_acc = cmd_valid && cmd_ready;

   half_period_timer #(.CNT_W(CNT_W)) u_timer (
      .clock_100Mhz (clock_100Mhz),
      .reset        (reset),
      .enable       (state != ST_IDLE),
      .cur_period   (cur_period),
      .tc           (tc)
   );

   always_comb begin
      clamped = cmd_period;
      if (cmd_period < P_MIN) begin
         clamped = P_MIN;
      end else if (cmd_period > P_MAX) begin
         clamped = P_MAX;
      end
   end

   // One extra bit keeps the step compare/add from wrapping near the ends of the range.
   always_comb begin
      cur_x  = {1'b0, cur_period};
      tgt_x  = {1'b0, target};
      ramped = cur_period;
      if (cur_x > tgt_x) begin
         ramped = (cur_x > tgt_x + STEP_X) ? CNT_W'(cur_x - STEP_X) : target;
      end else if (cur_x < tgt_x) begin
         ramped = (cur_x + STEP_X < tgt_x) ? CNT_W'(cur_x + STEP_X) : target;
      end
   end

   // An accepted command owns the transition in its cycle; TC-driven moves wait for the next TC.
   always_comb begin
      state_nxt  = state;
      target_nxt = target;
      unique case (state)
         ST_IDLE: begin
            if (cmd_acc && cmd_run) begin
               target_nxt = clamped;
               state_nxt  = (clamped == P_MAX) ? ST_CRUISE : ST_RAMP;
            end
         end
         ST_RAMP: begin
            if (cmd_acc) begin
               if (cmd_run) begin
                  target_nxt = clamped;
               end else begin
                  target_nxt = P_MAX;
                  state_nxt  = ST_STOP;
               end
            end else if (tc && (ramped == target)) begin
               state_nxt = ST_CRUISE;
            end
         end
         ST_CRUISE: begin
            if (cmd_acc) begin
               if (!cmd_run) begin
                  target_nxt = P_MAX;
                  state_nxt  = ST_STOP;
               end else if (clamped != target) begin
                  target_nxt = clamped;
                  state_nxt  = ST_RAMP;
               end
            end
         end
         ST_STOP: begin
            // Leave only on a falling edge so the final high phase is never truncated.
            if (tc && (ramped == P_MAX) && senal) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         target     <= P_MAX;
         cur_period <= P_MAX;
         senal      <= 1'b0;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         at_speed   <= 1'b0;
      end else begin
         state  <= state_nxt;
         target <= target_nxt;
         if (state_nxt == ST_IDLE) begin
            cur_period <= P_MAX;
            senal      <= 1'b0;
         end else if (tc) begin
            cur_period <= ramped;
            senal      <= ~senal;
         end
         cmd_ready <= (state_nxt != ST_STOP);
         busy      <= (state_nxt != ST_IDLE);
         at_speed  <= (state_nxt == ST_CRUISE);
      end
   end

endmodule

// File: tb/tb_step_rate_ramp_ctrl.sv
// Randomized scoreboard bench for step_rate_ramp_ctrl with a phase-level reference model.
module tb_step_rate_ramp_ctrl;

   localparam int CNT_W = 8;
   localparam int PMIN  = 4;
   localparam int PMAX  = 20;
   localparam int STEP  = 4;

   localparam int M_IDLE   = 0;
   localparam int M_RAMP   = 1;
   localparam int M_CRUISE = 2;
   localparam int M_STOP   = 3;

   typedef struct packed {
      logic             senal;
      logic             rdy;
      logic             busy;
      logic             at;
      logic [CNT_W-1:0] per;
   } obs_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_run = 1'b0;
   logic [CNT_W-1:0] cmd_period = '0;
   logic             cmd_ready, senal, busy, at_speed;
   logic [CNT_W-1:0] cur_period;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   obs_t exp_q[$];

   // Reference model: speed mode, current half-period, target, cycles left in the running phase.
   int   m_mode  = M_IDLE;
   int   m_per   = PMAX;
   int   m_tgt   = PMAX;
   int   m_left  = 0;
   logic m_level = 1'b0;

   step_rate_ramp_ctrl #(
      .CNT_W     (CNT_W),
      .PER_MIN   (PMIN),
      .PER_MAX   (PMAX),
      .RAMP_STEP (STEP)
   ) dut (
      .clock_100Mhz (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_run      (cmd_run),
      .cmd_period   (cmd_period),
      .senal        (senal),
      .busy         (busy),
      .at_speed     (at_speed),
      .cur_period   (cur_period)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic int clampv(input int p);
      if (p < PMIN) return PMIN;
      if (p > PMAX) return PMAX;
      return p;
   endfunction

   function automatic int toward(input int p, input int t);
      if (p > t) return (p - STEP > t) ? p - STEP : t;
      if (p < t) return (p + STEP < t) ? p + STEP : t;
      return p;
   endfunction

   always @(posedge clk) begin : model
      int   c, nper, nmode, ntgt;
      bit   acc, last;
      obs_t e;
      cyc++;
      if (reset) begin
         m_mode  = M_IDLE;
         m_per   = PMAX;
         m_tgt   = PMAX;
         m_left  = 0;
         m_level = 1'b0;
      end else begin
         acc   = cmd_valid && (m_mode != M_STOP);
         last  = (m_mode != M_IDLE) && (m_left == 1);
         nper  = last ? toward(m_per, m_tgt) : m_per;
         nmode = m_mode;
         ntgt  = m_tgt;
         c     = clampv(int'(cmd_period));
         if (acc && cmd_run) begin
            if (m_mode == M_IDLE) begin
               ntgt  = c;
               nmode = (c == PMAX) ? M_CRUISE : M_RAMP;
            end else if (m_mode == M_RAMP) begin
               ntgt = c;
            end else if (m_mode == M_CRUISE && c != m_tgt) begin
               ntgt  = c;
               nmode = M_RAMP;
            end
         end else if (acc && (m_mode == M_RAMP || m_mode == M_CRUISE)) begin
            ntgt  = PMAX;
            nmode = M_STOP;
         end
         if (!acc && m_mode == M_RAMP && last && nper == m_tgt) nmode = M_CRUISE;
         if (m_mode == M_STOP && last && nper == PMAX && m_level) nmode = M_IDLE;

         if (nmode == M_IDLE) begin
            m_level = 1'b0;
            nper    = PMAX;
            m_left  = 0;
         end else if (m_mode == M_IDLE) begin
            m_left = PMAX;
         end else if (last) begin
            m_level = ~m_level;
            m_left  = nper;
         end else begin
            m_left--;
         end
         m_mode = nmode;
         m_per  = nper;
         m_tgt  = ntgt;

         e.senal = m_level;
         e.rdy   = (m_mode != M_STOP);
         e.busy  = (m_mode != M_IDLE);
         e.at    = (m_mode == M_CRUISE);
         e.per   = CNT_W'(m_per);
         exp_q.push_back(e);
      end
   end

   always @(negedge clk) begin : monitor
      obs_t act, e;
      act.senal = senal;
      act.rdy   = cmd_ready;
      act.busy  = busy;
      act.at    = at_speed;
      act.per   = cur_period;
      if (reset) begin
         exp_q.delete();
         e.senal = 1'b0;
         e.rdy   = 1'b1;
         e.busy  = 1'b0;
         e.at    = 1'b0;
         e.per   = CNT_W'(PMAX);
         check("reset_outputs", 32'(act), 32'(e));
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("outputs{senal,rdy,busy,at,per}", 32'(act), 32'(e));
      end
   end

   task automatic send(input logic run, input int per);
      bit done;
      done = 1'b0;
      @(posedge clk);
      #1;
      cmd_valid  = 1'b1;
      cmd_run    = run;
      cmd_period = CNT_W'(per);
      for (int i = 0; i < 600 && !done; i++) begin
         @(negedge clk);
         if (cmd_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      check("cmd_accept_in_time", 32'(done), 32'(1));
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      check("reached_idle", 32'(done), 32'(1));
   endtask

   task automatic wait_period(input int p);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (int'(cur_period) == p) done = 1'b1;
      end
      check("reached_period", 32'(done), 32'(1));
   endtask

   initial begin : stim
      bit   seen;
      logic prev;
      int   r, p;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Start and ramp to 8, retarget to 16 while passing through 12.
      send(1'b1, 8);
      wait_period(12);
      send(1'b1, 16);
      repeat (80) @(posedge clk);

      // Ramp to fastest speed, stop, with a command held through the stop.
      send(1'b1, 4);
      repeat (120) @(posedge clk);
      send(1'b0, 0);
      send(1'b1, 10);
      repeat (150) @(posedge clk);

      // Clamping at both ends; the upper clamp goes straight to cruise.
      send(1'b0, 0);
      wait_idle();
      send(1'b1, 1);
      repeat (120) @(posedge clk);
      send(1'b0, 0);
      wait_idle();
      send(1'b1, 50);

      // Run command landing exactly on a terminal-count cycle at period 20.
      seen = 1'b0;
      prev = senal;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (senal != prev) seen = 1'b1;
      end
      check("edge_seen", 32'(seen), 32'(1));
      repeat (19) @(posedge clk);
      #1;
      cmd_valid  = 1'b1;
      cmd_run    = 1'b1;
      cmd_period = CNT_W'(12);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (100) @(posedge clk);

      // Reset during the first high phase of a ramp.
      send(1'b0, 0);
      wait_idle();
      send(1'b1, 8);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (senal) seen = 1'b1;
      end
      check("senal_high_before_reset", 32'(seen), 32'(1));
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_senal_immediate", 32'(senal), 32'(0));
      check("rst_cur_period", 32'(cur_period), 32'(PMAX));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_at_speed", 32'(at_speed), 32'(0));
      check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
      @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      // Random command stream.
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 3);
         p = $urandom_range(0, 30);
         send(r != 0, p);
         repeat ($urandom_range(0, 70)) @(posedge clk);
      end

      send(1'b0, 0);
      wait_idle();
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/step_rate_ramp_ctrl.md
# step_rate_ramp_ctrl

Speed controller for the motor step/drive square wave. It takes run/stop commands carrying a target half-period and generates `senal` by ramping the divider half-period linearly toward the target, one adjustment per output edge. The block replaces the fixed divider on the motor drive path and feeds the motor driver stage directly.

## Interface
- `CNT_W`, 22: width of the half-period counter and of all period values.
- `PER_MIN`, 2000: shortest allowed half-period in clocks, i.e. the fastest speed.
- `PER_MAX`, 20000: longest half-period in clocks. Used as the start and stop speed.
- `RAMP_STEP`, 100: half-period change applied per output edge while ramping.

Ports:
- `clock_100Mhz`, in, 1: system clock; the only clock.
- `reset`, in, 1: asynchronous, active-high.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_run`, in, 1: 1 = run at `cmd_period`; 0 = decelerate and stop.
- `cmd_period`, in, CNT_W: target half-period. Ignored when `cmd_run`=0.
- `senal`, out, 1: drive square wave.
- `busy`, out, 1: high in any state other than IDLE.
- `at_speed`, out, 1: high in CRUISE.
- `cur_period`, out, CNT_W: half-period currently in use.

## Operation
- **States:** IDLE, RAMP, CRUISE, STOP. All outputs are registered.
- **Target clamp:** an accepted run target is clamped to [PER_MIN, PER_MAX] before it is stored.
- **Counter:** counts 0 to `cur_period`-1. Reaching `cur_period`-1 is the terminal count (TC). At TC:
  - the counter returns to 0,
  - `senal` toggles,
  - the period is updated.
- **Period update at TC:**
  - If `cur_period` > target, the new value is max(`cur_period`-RAMP_STEP, target).
  - If `cur_period` < target, the new value is min(`cur_period`+RAMP_STEP, target).
  - Arithmetic is done in CNT_W+1 bits so the result never wraps.
- **IDLE:**
  - `senal`=0, counter held at 0, `cur_period`=PER_MAX.
  - A run command loads the target and moves to RAMP, or to CRUISE if the clamped target equals PER_MAX.
  - A stop command is accepted and ignored.
- **RAMP:** when the updated period equals the target, move to CRUISE.
- **CRUISE:** a run command with a different target moves back to RAMP.
- **STOP:**
  - Entered from RAMP or CRUISE on a stop command. Sets target = PER_MAX.
  - `cmd_ready`=0 throughout STOP.
  - Exit to IDLE at the TC where the updated period equals PER_MAX and `senal` toggles 1→0. This guarantees the last high phase completes.
- **`cmd_ready`:** high in IDLE, RAMP and CRUISE.

## Timing
- **Reset values:**
  - `senal`=0, `cur_period`=PER_MAX, counter 0, target PER_MAX.
  - state IDLE, `cmd_ready`=1, `busy`=0, `at_speed`=0.
- **Mid-operation reset:** `senal` drops to 0 immediately on assertion, with no completion of the current phase.
- **Start latency:** for a run command accepted at cycle N:
  - `busy`=1 at N+1,
  - first `senal` rising edge at N+PER_MAX+1,
  - every later half-period uses the period updated at the preceding TC.
- **Command changes take effect only at the next TC.**
- **Command and TC in the same cycle:** the TC update uses the old target, and the new target is stored. The state transition it implies is evaluated at the next TC.
- **Run to the current period from RAMP:** the block moves to CRUISE at the next TC.
- **`at_speed`** asserts in the cycle after the TC where the final period update lands.

## Structure
- **Shared package `motor_pkg`:** state enum `ramp_state_t`, plus default localparams for the PER_MIN, PER_MAX and RAMP_STEP values.
- **Sub-module `half_period_timer`:**
  - Inputs: `cur_period`, enable.
  - Outputs: a TC pulse.
  - It holds the counter and the TC compare.
- The parent block holds the FSM, the target register, the clamp/ramp arithmetic and `senal`.

## Test plan
All scenarios use PER_MIN=4, PER_MAX=20, RAMP_STEP=4.

1. **Reset mid-run:** assert `reset` while `senal`=1 and the block is in RAMP → `senal`=0 immediately; all outputs return to their reset values; `cmd_ready`=1.
2. **Start and ramp:** run with `cmd_period`=8 accepted at cycle 0 → first rise at cycle 21; `cur_period` sequence 20,16,12,8; `at_speed`=1 after the third TC.
3. **Clamping:** run with `cmd_period`=1 → clamps to 4. Run with `cmd_period`=50 → clamps to 20; the block goes IDLE → CRUISE directly with no ramp.
4. **Retarget while ramping:** in RAMP at `cur_period`=12, run with 16 → the next TC gives 16; state is CRUISE.
5. **Stop:**
   - Stop from CRUISE at period 4 → `cmd_ready`=0; periods 8,12,16,20; IDLE entered on a 1→0 edge with `senal`=0.
   - A `cmd_valid` during STOP is not accepted.
6. **Simultaneous command and TC:** run with 12 arriving on the TC cycle while at 20 with target 20 → period stays 20 for that update, then 16, then 12.
